// File: rtl/hue_wheel_pkg.sv
// -----------------------------------------------------------------------------
// hue_pkg
// Shared types and helpers for the hue_wheel block.
//   sector_t      : hue sector S0..S5 (red->yellow->green->cyan->blue->magenta)
//   SECTOR_COUNT  : number of sectors in one hue revolution
//   CH_R/CH_G/CH_B: channel selectors for channel_duty()
//   next_sector() : sector sequencing, S5 wraps back to S0
//   channel_duty(): sector/level to per-channel duty mapping. The testbench
//                   uses this same function as its colour model.
// -----------------------------------------------------------------------------
package hue_pkg;

    localparam int SECTOR_COUNT = 6;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } sector_t;

    // Advance one sector; the last sector (and any illegal encoding) returns to S0.
    function automatic sector_t next_sector(input sector_t s);
        sector_t nxt;
        if ({29'd0, s} >= 32'(SECTOR_COUNT - 1)) begin
            nxt = S0;
        end else begin
            nxt = sector_t'(s + 3'd1);
        end
        return nxt;
    endfunction

    // Duty of one channel for a given sector and ramp level.
    // up = lvl, dn = max - lvl.
    function automatic logic [15:0] channel_duty(input sector_t     s,
                                                 input logic [1:0]  ch,
                                                 input logic [15:0] lvl,
                                                 input logic [15:0] max);
        logic [15:0] up;
        logic [15:0] dn;
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
        logic [15:0] res;
        up = lvl;
        dn = max - lvl;
        case (s)
            S0:      begin r = max;   g = up;    b = 16'd0; end
            S1:      begin r = dn;    g = max;   b = 16'd0; end
            S2:      begin r = 16'd0; g = max;   b = up;    end
            S3:      begin r = 16'd0; g = dn;    b = max;   end
            S4:      begin r = up;    g = 16'd0; b = max;   end
            S5:      begin r = max;   g = 16'd0; b = dn;    end
            default: begin r = max;   g = 16'd0; b = 16'd0; end
        endcase
        case (ch)
            CH_R:    res = r;
            CH_G:    res = g;
            CH_B:    res = b;
            default: res = 16'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hue_wheel_if.sv
// -----------------------------------------------------------------------------
// hue_wheel_if
// Control and duty bus of the hue_wheel block.
//   enable       : ramp/prescaler run control      (master -> slave)
//   period_start : PWM period start pulse          (master -> slave)
//   pwm_r/g/b    : W-bit duty values               (slave -> master)
//   sector       : current hue sector 0..5         (slave -> master)
//   wrap         : one-cycle pulse on sector 5->0  (slave -> master)
// W = $clog2(PWM_MAX+1).
// -----------------------------------------------------------------------------
interface hue_wheel_if #(
    parameter int PWM_MAX = 1200
) ();
    localparam int W = $clog2(PWM_MAX + 1);

    logic         enable;
    logic         period_start;
    logic [W-1:0] pwm_r;
    logic [W-1:0] pwm_g;
    logic [W-1:0] pwm_b;
    logic [2:0]   sector;
    logic         wrap;

    modport master (
        output enable,
        output period_start,
        input  pwm_r,
        input  pwm_g,
        input  pwm_b,
        input  sector,
        input  wrap
    );

    modport slave (
        input  enable,
        input  period_start,
        output pwm_r,
        output pwm_g,
        output pwm_b,
        output sector,
        output wrap
    );
endinterface

// File: rtl/hue_wheel_step_prescaler.sv
// -----------------------------------------------------------------------------
// step_prescaler
// Divides the clock down to one ramp-step tick every STEP_CYCLES enabled clocks.
//   clk      : system clock
//   rst      : synchronous active-high reset (count returns to 0)
//   i_enable : count while high, hold the count while low
//   o_tick   : high on the enabled cycle where the count is STEP_CYCLES-1
// -----------------------------------------------------------------------------
module step_prescaler #(
    parameter int STEP_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_tick
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] r_pcnt;
    logic          w_at_last;

    // Terminal-count detect; the tick is only meaningful while enabled.
    always_comb begin
        w_at_last = (r_pcnt == LAST);
        o_tick    = i_enable & w_at_last;
    end

    // Prescaler counter: wraps to 0 after the terminal count, frozen when disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= {CW{1'b0}};
        end else if (i_enable) begin
            if (w_at_last) begin
                r_pcnt <= {CW{1'b0}};
            end else begin
                r_pcnt <= r_pcnt + CW'(1);
            end
        end else begin
            r_pcnt <= r_pcnt;
        end
    end
endmodule

// File: rtl/hue_wheel.sv
// -----------------------------------------------------------------------------
// hue_wheel
// Sweeps three PWM duty values around the hue circle for an RGB LED driver.
// Parameters: PWM_MAX (full-scale duty), STEP_SIZE (duty per step, >=1),
//             STEP_CYCLES (clocks per step, >=1).
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : hue_wheel_if.slave (enable, period_start in; pwm_r/g/b, sector,
//         wrap out)
// Build option: HUE_WHEEL_PERIOD_SYNC_EN
//   defined   - duty outputs load only on period_start edges, so the pwm
//               stage never sees a change inside a period
//   undefined - duty outputs load every clock; period_start is ignored
// -----------------------------------------------------------------------------
module hue_wheel
    import hue_pkg::*;
#(
    parameter int PWM_MAX     = 1200,
    parameter int STEP_SIZE   = 12,
    parameter int STEP_CYCLES = 12000
) (
    input  logic      clk,
    input  logic      rst,
    hue_wheel_if.slave bus
);
    localparam int W = $clog2(PWM_MAX + 1);
    localparam logic [W-1:0] MAX_W = W'(PWM_MAX);

    sector_t      r_sector;
    sector_t      w_sector_nxt;
    logic [W-1:0] r_lvl;
    logic [W-1:0] w_lvl_nxt;
    logic         r_wrap;
    logic         w_wrap_nxt;
    logic         w_tick;
    logic [31:0]  w_sum;
    logic [W-1:0] w_tgt_r;
    logic [W-1:0] w_tgt_g;
    logic [W-1:0] w_tgt_b;
    logic [W-1:0] r_pwm_r;
    logic [W-1:0] r_pwm_g;
    logic [W-1:0] r_pwm_b;

    step_prescaler #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_prescaler (
        .clk      (clk),
        .rst      (rst),
        .i_enable (bus.enable),
        .o_tick   (w_tick)
    );

    // Sector / level state register; wrap is registered so it follows the S5->S0 edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sector <= S0;
            r_lvl    <= {W{1'b0}};
            r_wrap   <= 1'b0;
        end else begin
            r_sector <= w_sector_nxt;
            r_lvl    <= w_lvl_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    // Ramp step: saturate at full scale, then spend one more step at full scale
    // before moving to the next sector with the level cleared.
    always_comb begin
        w_sector_nxt = r_sector;
        w_lvl_nxt    = r_lvl;
        w_wrap_nxt   = 1'b0;
        w_sum        = 32'(r_lvl) + 32'(STEP_SIZE);
        if (w_tick) begin
            if (r_lvl < MAX_W) begin
                if (w_sum >= 32'(PWM_MAX)) begin
                    w_lvl_nxt = MAX_W;
                end else begin
                    w_lvl_nxt = w_sum[W-1:0];
                end
            end else begin
                w_lvl_nxt    = {W{1'b0}};
                w_sector_nxt = next_sector(r_sector);
                w_wrap_nxt   = (r_sector == S5);
            end
        end else begin
            w_sector_nxt = r_sector;
            w_lvl_nxt    = r_lvl;
        end
    end

    // Target duties, combinational from the state registers.
    always_comb begin
        w_tgt_r = W'(channel_duty(r_sector, CH_R, 16'(r_lvl), 16'(PWM_MAX)));
        w_tgt_g = W'(channel_duty(r_sector, CH_G, 16'(r_lvl), 16'(PWM_MAX)));
        w_tgt_b = W'(channel_duty(r_sector, CH_B, 16'(r_lvl), 16'(PWM_MAX)));
    end

`ifdef HUE_WHEEL_PERIOD_SYNC_EN
    // Duty output registers: reload only at the start of a PWM period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_r <= MAX_W;
            r_pwm_g <= {W{1'b0}};
            r_pwm_b <= {W{1'b0}};
        end else if (bus.period_start) begin
            r_pwm_r <= w_tgt_r;
            r_pwm_g <= w_tgt_g;
            r_pwm_b <= w_tgt_b;
        end else begin
            r_pwm_r <= r_pwm_r;
            r_pwm_g <= r_pwm_g;
            r_pwm_b <= r_pwm_b;
        end
    end
`else
    // period_start is kept on the bus for a stable interface but has no effect here.
    logic w_unused_period_start;
    assign w_unused_period_start = bus.period_start;

    // Duty output registers: follow the target one clock behind the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_r <= MAX_W;
            r_pwm_g <= {W{1'b0}};
            r_pwm_b <= {W{1'b0}};
        end else begin
            r_pwm_r <= w_tgt_r;
            r_pwm_g <= w_tgt_g;
            r_pwm_b <= w_tgt_b;
        end
    end
`endif

    assign bus.pwm_r  = r_pwm_r;
    assign bus.pwm_g  = r_pwm_g;
    assign bus.pwm_b  = r_pwm_b;
    assign bus.sector = 3'(r_sector);
    assign bus.wrap   = r_wrap;
endmodule
